// File: rtl/cache_axi_ctrl_if.sv
// AXI single-beat write/read channel bundle between cache_axi_ctrl (master) and the bus port.
interface cache_axi_ctrl_if;
   logic       awvalid;
   logic       awready;
   logic       wvalid;
   logic       wready;
   logic       bvalid;
   logic       bready;
   logic [1:0] bresp;
   logic       arvalid;
   logic       arready;
   logic       rvalid;
   logic       rready;
   logic [1:0] rresp;

   modport master (
      output awvalid, wvalid, bready, arvalid, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rresp
   );

   modport slave (
      input  awvalid, wvalid, bready, arvalid, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rresp
   );
endinterface

// File: rtl/cache_axi_ctrl.sv
// Miss sequencer: optional dirty-line writeback then line refill, one single-beat AXI
// transaction per word, with a per-handshake watchdog.
module cache_axi_ctrl #(
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_req,
   input  logic             i_dirty,
   output logic             o_ack,
   output logic             o_error,
   output logic             o_start_write,
   output logic             o_start_read,
   output logic             o_wb_sel,
   output logic             o_beat_done,
   input  logic             i_count_done,
   cache_axi_ctrl_if.master axi
);
   typedef enum logic [3:0] {
      IDLE, WB_START, WB_AW, WB_B, WB_CHK, RF_START, RF_AR, RF_R, RF_CHK, DONE
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [TIMEOUT_W-1:0] wd;
   logic                 aw_done;
   logic                 w_done;
   logic                 wb_sel_q;
   logic                 error_q;
   logic                 aw_hs;
   logic                 w_hs;
   logic                 timeout;
   logic                 wait_st;

   assign aw_hs   = axi.awvalid & axi.awready;
   assign w_hs    = axi.wvalid & axi.wready;
   assign timeout = &wd;
   assign wait_st = (state == WB_AW) || (state == WB_B) || (state == RF_AR) || (state == RF_R);
   assign o_error = error_q;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) state <= IDLE;
      else       state <= state_nx;
   end

   // A handshake in the expiry cycle takes priority over the watchdog.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (i_req) state_nx = i_dirty ? WB_START : RF_START;
         WB_START: state_nx = WB_AW;
         WB_AW: begin
            if ((aw_done | aw_hs) && (w_done | w_hs)) state_nx = WB_B;
            else if (timeout && !aw_hs && !w_hs)      state_nx = DONE;
         end
         WB_B: begin
            if (axi.bvalid)   state_nx = (axi.bresp != 2'b00) ? DONE : WB_CHK;
            else if (timeout) state_nx = DONE;
         end
         WB_CHK:   state_nx = i_count_done ? RF_START : WB_AW;
         RF_START: state_nx = RF_AR;
         RF_AR: begin
            if (axi.arready)  state_nx = RF_R;
            else if (timeout) state_nx = DONE;
         end
         RF_R: begin
            if (axi.rvalid)   state_nx = (axi.rresp != 2'b00) ? DONE : RF_CHK;
            else if (timeout) state_nx = DONE;
         end
         RF_CHK:   state_nx = i_count_done ? DONE : RF_AR;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_ack         = 1'b0;
      o_start_write = 1'b0;
      o_start_read  = 1'b0;
      o_wb_sel      = wb_sel_q;
      o_beat_done   = 1'b0;
      axi.awvalid   = 1'b0;
      axi.wvalid    = 1'b0;
      axi.bready    = 1'b0;
      axi.arvalid   = 1'b0;
      axi.rready    = 1'b0;
      case (state)
         WB_START: begin
            o_start_write = 1'b1;
            o_wb_sel      = 1'b1;
         end
         WB_AW: begin
            axi.awvalid = !aw_done;
            axi.wvalid  = !w_done;
         end
         WB_B: begin
            axi.bready  = 1'b1;
            o_beat_done = axi.bvalid && (axi.bresp == 2'b00);
         end
         RF_START: begin
            o_start_read = 1'b1;
            o_wb_sel     = 1'b0;
         end
         RF_AR: axi.arvalid = 1'b1;
         RF_R: begin
            axi.rready  = 1'b1;
            o_beat_done = axi.rvalid && (axi.rresp == 2'b00);
         end
         DONE:    o_ack = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         wd       <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         wb_sel_q <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         wb_sel_q <= o_wb_sel;
         if (state_nx != state)        wd <= '0;
         else if (wait_st && !timeout) wd <= wd + 1'b1;
         if (state == WB_AW) begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
         end else begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         // Only error exits lead from a wait state straight to DONE.
         if (state == IDLE && i_req)            error_q <= 1'b0;
         else if (wait_st && state_nx == DONE)  error_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cache_axi_ctrl.sv
// Randomized bench for cache_axi_ctrl: reactive AXI slave, transfer-counter model and
// per-service expectations derived from word count, dirty flag and injected errors.
module tb_cache_axi_ctrl;
   logic clk;
   logic arst;
   logic i_req, i_dirty, i_count_done;
   logic o_ack, o_error, o_start_write, o_start_read, o_wb_sel, o_beat_done;

   cache_axi_ctrl_if axi ();

   cache_axi_ctrl #(.TIMEOUT_W(8)) dut (
      .clk(clk), .arst(arst), .i_req(i_req), .i_dirty(i_dirty),
      .o_ack(o_ack), .o_error(o_error), .o_start_write(o_start_write),
      .o_start_read(o_start_read), .o_wb_sel(o_wb_sel), .o_beat_done(o_beat_done),
      .i_count_done(i_count_done), .axi(axi)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // slave / transfer-block configuration
   bit zero_wait = 1'b1;
   bit ar_never  = 1'b0;
   int max_dly   = 3;
   int berr_at   = -1;
   int rerr_at   = -1;
   int aw_hold   = 0;
   int bdly_fix  = -1;
   int n_words   = 16;

   // slave state
   bit aw_got, w_got, b_pend, r_pend;
   int b_dly, r_dly, b_cnt, r_cnt, beat_cnt;
   bit p_aw, p_w, p_b, p_ar, p_r, p_sw, p_sr, p_bd;
   bit awv_wait, wv_wait, arv_wait;

   // monitor
   int cyc = 0;
   int mon_beats, mon_sw, mon_sr, mon_ack, mon_aw, mon_w, mon_ar;
   int sw_cyc, sr_cyc, ack_cyc, err_at_ack, arv_at_ack, w_at_b0;
   int wbsel_bad, proto_bad, drop_bad, ar_run, ar_max;

   initial begin : slave
      forever begin
         @(negedge clk);
         cyc++;
         if (!arst) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; beat_cnt = 0;
            {p_aw, p_w, p_b, p_ar, p_r, p_sw, p_sr, p_bd} = '0;
            {awv_wait, wv_wait, arv_wait} = '0;
            axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
            axi.arready = 0; axi.rvalid = 0; axi.rresp = 2'b00;
            i_count_done = 0;
         end else begin
            if (p_aw) aw_got = 1;
            if (p_w)  w_got  = 1;
            if (p_b) begin b_pend = 0; aw_got = 0; w_got = 0; b_cnt++; end
            if (p_ar) begin r_pend = 1; r_dly = zero_wait ? 0 : $urandom_range(max_dly, 0); end
            if (p_r) begin r_pend = 0; r_cnt++; end
            if (p_sw || p_sr) beat_cnt = 0;
            else if (p_bd)    beat_cnt++;
            if (aw_got && w_got && !b_pend) begin
               b_pend = 1;
               b_dly  = (bdly_fix >= 0) ? bdly_fix : (zero_wait ? 0 : $urandom_range(max_dly, 0));
            end
            axi.bvalid = b_pend && (b_dly == 0);
            axi.bresp  = (axi.bvalid && b_cnt == berr_at) ? 2'b10 : 2'b00;
            if (b_pend && b_dly > 0) b_dly--;
            axi.rvalid = r_pend && (r_dly == 0);
            axi.rresp  = (axi.rvalid && r_cnt == rerr_at) ? 2'b10 : 2'b00;
            if (r_pend && r_dly > 0) r_dly--;
            axi.awready = zero_wait || ($urandom_range(max_dly, 0) == 0);
            axi.wready  = zero_wait || ($urandom_range(max_dly, 0) == 0);
            if (aw_hold > 0 && b_cnt == 0) begin
               if (awv_wait) aw_hold--;
               axi.awready = (aw_hold == 0);
               axi.wready  = 1;
            end
            axi.arready  = !ar_never && (zero_wait || ($urandom_range(max_dly, 0) == 0));
            i_count_done = (beat_cnt == n_words);
            #1;
            p_aw = axi.awvalid && axi.awready;
            p_w  = axi.wvalid && axi.wready;
            p_b  = axi.bvalid && axi.bready;
            p_ar = axi.arvalid && axi.arready;
            p_r  = axi.rvalid && axi.rready;
            p_sw = o_start_write; p_sr = o_start_read; p_bd = o_beat_done;
            if (p_aw) mon_aw++;
            if (p_w)  mon_w++;
            if (p_ar) mon_ar++;
            if (p_b && b_cnt == 0) w_at_b0 = mon_w;
            if (o_start_write) begin mon_sw++; sw_cyc = cyc; end
            if (o_start_read)  begin mon_sr++; sr_cyc = cyc; end
            if (o_beat_done) mon_beats++;
            if (o_beat_done && (o_start_write || o_start_read || (!axi.bready && !axi.rready))) proto_bad++;
            if (o_ack) begin mon_ack++; ack_cyc = cyc; err_at_ack = o_error; arv_at_ack = axi.arvalid; end
            if ((axi.awvalid && !o_wb_sel) || (axi.arvalid && o_wb_sel)) wbsel_bad++;
            if ((awv_wait && !axi.awvalid) || (wv_wait && !axi.wvalid)) drop_bad++;
            if (arv_wait && !axi.arvalid && !ar_never) drop_bad++;
            awv_wait = axi.awvalid && !axi.awready;
            wv_wait  = axi.wvalid && !axi.wready;
            arv_wait = axi.arvalid && !axi.arready;
            ar_run = axi.arvalid ? ar_run + 1 : 0;
            if (ar_run > ar_max) ar_max = ar_run;
         end
      end
   end

   int req_cyc;

   task automatic clear_mon();
      mon_beats = 0; mon_sw = 0; mon_sr = 0; mon_ack = 0; mon_aw = 0; mon_w = 0; mon_ar = 0;
      sw_cyc = 0; sr_cyc = 0; ack_cyc = 0; err_at_ack = 0; arv_at_ack = 0; w_at_b0 = 0;
      wbsel_bad = 0; proto_bad = 0; drop_bad = 0; ar_run = 0; ar_max = 0;
      b_cnt = 0; r_cnt = 0;
   endtask

   task automatic start_req(input bit dirty);
      @(negedge clk); #2;
      clear_mon();
      i_req = 1; i_dirty = dirty; req_cyc = cyc;
      @(negedge clk); #2;
      i_req = 0; i_dirty = 0;
      check("error_cleared_on_req", o_error, 0);
   endtask

   task automatic wait_ack(input string name);
      int t = 0;
      while (mon_ack == 0 && t < 8000) begin @(negedge clk); #2; t++; end
      check({name, "_ack_seen"}, mon_ack, 1);
   endtask

   task automatic run_service(input string name, input bit dirty, input int n,
                              input int berr, input int rerr, input bit zw);
      int exp_beats = 0, exp_aw = 0, exp_ar = 0;
      bit exp_err = 0, exp_sr = 1;
      n_words = n; berr_at = berr; rerr_at = rerr; zero_wait = zw;
      if (dirty) begin
         if (berr >= 0 && berr < n) begin
            exp_aw = berr + 1; exp_beats = berr; exp_err = 1; exp_sr = 0;
         end else begin
            exp_aw = n; exp_beats = n;
         end
      end
      if (exp_sr) begin
         if (rerr >= 0 && rerr < n) begin
            exp_ar = rerr + 1; exp_beats += rerr; exp_err = 1;
         end else begin
            exp_ar = n; exp_beats += n;
         end
      end
      start_req(dirty);
      wait_ack(name);
      check({name, "_beats"}, mon_beats, exp_beats);
      check({name, "_aw"}, mon_aw, exp_aw);
      check({name, "_w"}, mon_w, exp_aw);
      check({name, "_ar"}, mon_ar, exp_ar);
      check({name, "_start_write"}, mon_sw, int'(dirty));
      check({name, "_start_read"}, mon_sr, int'(exp_sr));
      check({name, "_error"}, err_at_ack, int'(exp_err));
      check({name, "_protocol"}, wbsel_bad + proto_bad + drop_bad, 0);
      if (dirty && exp_sr) check({name, "_wr_before_rd"}, int'(sw_cyc < sr_cyc), 1);
      if (zw && !dirty && !exp_err) check({name, "_latency"}, ack_cyc - req_cyc, 2 + 3 * n);
   endtask

   initial begin : main
      int t;
      arst = 0; i_req = 0; i_dirty = 0; i_count_done = 0;
      clear_mon();
      repeat (3) @(negedge clk);
      #2;
      check("reset_outputs", int'({o_ack, o_error, o_start_write, o_start_read, o_wb_sel, o_beat_done,
            axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 0);
      arst = 1;
      repeat (2) @(negedge clk);

      run_service("clean16", 0, 16, -1, -1, 1);
      check("clean16_ack_cycle", ack_cyc - req_cyc, 50);
      run_service("dirty16", 1, 16, -1, -1, 1);

      aw_hold = 3;
      run_service("wready_first", 1, 4, -1, -1, 1);
      check("wready_first_w_beat0", w_at_b0, 1);
      aw_hold = 0;

      run_service("rresp_err5", 0, 16, -1, 5, 1);
      run_service("after_err", 0, 4, -1, -1, 1);
      run_service("bresp_err2", 1, 8, 2, -1, 0);

      ar_never = 1; n_words = 4; berr_at = -1; rerr_at = -1; zero_wait = 1;
      start_req(0);
      wait_ack("ar_timeout");
      check("ar_timeout_error", err_at_ack, 1);
      check("ar_timeout_len", int'(ar_max >= 255 && ar_max <= 256), 1);
      check("ar_timeout_arvalid_low", arv_at_ack, 0);
      check("ar_timeout_beats", mon_beats, 0);
      ar_never = 0;
      @(negedge clk); #2;

      n_words = 16; bdly_fix = 4; zero_wait = 1;
      start_req(1);
      t = 0;
      while (!(b_cnt == 7 && axi.bready) && t < 2000) begin @(negedge clk); #2; t++; end
      check("rst_reached_wb_b7", int'(b_cnt == 7 && axi.bready), 1);
      check("rst_wb_sel_high", o_wb_sel, 1);
      arst = 0;
      @(posedge clk); #1;
      check("rst_outputs_zero", int'({o_ack, o_error, o_start_write, o_start_read, o_wb_sel, o_beat_done,
            axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 0);
      @(negedge clk); #2;
      bdly_fix = -1; mon_ack = 0;
      arst = 1;
      repeat (5) @(negedge clk);
      #2;
      check("rst_no_ack", mon_ack, 0);
      run_service("post_rst", 1, 16, -1, -1, 1);

      for (int i = 0; i < 20; i++) begin
         int n, be, re;
         bit d;
         d  = 1'($urandom_range(1, 0));
         n  = $urandom_range(8, 1);
         be = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
         re = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
         run_service($sformatf("rand%0d", i), d, n, be, re, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
